// File: rtl/seed_round_stream_ctrl.sv
// seed_round_stream_ctrl: byte-serial sequencer for the SEED round datapath.
// Accepts a block, streams it MSB byte first through the round datapath for
// ROUNDS rounds (feeding each round's captured bytes back as the next source)
// and presents the final block on a valid/ready output.
// Optional feature macro: SEED_CTRL_ABORT_EN adds an 'abort' input that drops
// an in-flight or pending block.
module seed_round_stream_ctrl #(
    parameter int BLOCK_BYTES = 16,
    parameter int ROUNDS      = 16,
    parameter int LAT         = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
`ifdef SEED_CTRL_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [8*BLOCK_BYTES-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8*BLOCK_BYTES-1:0]   out_data,
    output logic [7:0]                 rnd_lr0,
    output logic                       rnd_valid,
    output logic                       rnd_sk_req,
    output logic [4:0]                 rnd_counter,
    input  logic [7:0]                 rnd_lr1,
    output logic                       busy
);

    localparam int BW = 8 * BLOCK_BYTES;

    // Cycle indices within a round: issue window is [0, ISSUE_END),
    // capture window is [CAP_START, CYC_LAST].
    localparam logic [6:0] ISSUE_END = 7'(BLOCK_BYTES);
    localparam logic [6:0] CAP_START = 7'(LAT);
    localparam logic [6:0] CYC_LAST  = 7'(LAT + BLOCK_BYTES - 1);
    localparam logic [4:0] R_LAST    = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   src_q;
    logic [BW-1:0]   dst_q;
    logic [BW-1:0]   dst_d;
    logic [BW-1:0]   out_q;
    logic [4:0]      r_q;
    logic [6:0]      cyc_q;
    logic            issue;
    logic            capture;
    logic            abort_hit;

    assign issue   = (state_q == S_RUN) && (cyc_q < ISSUE_END);
    assign capture = (state_q == S_RUN) && (cyc_q >= CAP_START) && (cyc_q <= CYC_LAST);

`ifdef SEED_CTRL_ABORT_EN
    assign abort_hit = abort && (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Destination buffer with the returned byte shifted in at the LSB end;
    // used both for ordinary capture and for the end-of-round handoff so the
    // final byte of the round is included.
    always_comb begin
        dst_d = dst_q;
        if (capture) dst_d = {dst_q[BW-9:0], rnd_lr1};
    end

    // Controller FSM: state, buffers, round/cycle counters and result register.
    always_ff @(posedge clk) begin
        if (!reset_n || abort_hit) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            out_q   <= '0;
            r_q     <= '0;
            cyc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        src_q   <= in_data;
                        dst_q   <= '0;
                        r_q     <= '0;
                        cyc_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Source is consumed from the top, one byte per issue cycle.
                    if (issue) src_q <= src_q << 8;
                    dst_q <= dst_d;
                    if (cyc_q == CYC_LAST) begin
                        cyc_q <= '0;
                        if (r_q == R_LAST) begin
                            out_q   <= dst_d;
                            state_q <= S_DONE;
                        end else begin
                            src_q <= dst_d;
                            r_q   <= r_q + 5'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 7'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out_data    = out_q;
    assign rnd_valid   = issue;
    assign rnd_sk_req  = issue;
    assign rnd_lr0     = issue ? src_q[BW-1 -: 8] : 8'h00;
    assign rnd_counter = (state_q == S_IDLE) ? 5'd0 : r_q;

endmodule

// File: tb/tb_seed_round_stream_ctrl.sv
// Scoreboard bench for seed_round_stream_ctrl: three instances
// (defaults; ROUNDS=2; LAT=1/ROUNDS=3) each with a behavioural datapath
// (delay line of LAT cycles, optionally XORing the round index).
module tb_seed_round_stream_ctrl;

    localparam int ND      = 3;
    localparam int RND[ND] = '{16, 2, 3};
    localparam int LATS[ND] = '{8, 8, 1};

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [ND-1:0]       in_valid = '0;
    logic [ND-1:0][127:0] in_data = '0;
    logic [ND-1:0]       out_ready = '1;
    logic [ND-1:0]       in_ready;
    logic [ND-1:0]       out_valid;
    logic [ND-1:0][127:0] out_data;
    logic [ND-1:0][7:0]  lr0;
    logic [ND-1:0][7:0]  lr1;
    logic [ND-1:0]       rv;
    logic [ND-1:0]       sk;
    logic [ND-1:0][4:0]  rc;
    logic [ND-1:0]       busy;
`ifdef SEED_CTRL_ABORT_EN
    logic [ND-1:0]       abort = '0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        seed_round_stream_ctrl #(.BLOCK_BYTES(16), .ROUNDS(RND[g]), .LAT(LATS[g])) u_dut (
            .clk(clk),
            .reset_n(reset_n),
`ifdef SEED_CTRL_ABORT_EN
            .abort(abort[g]),
`endif
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_data(in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data(out_data[g]),
            .rnd_lr0(lr0[g]),
            .rnd_valid(rv[g]),
            .rnd_sk_req(sk[g]),
            .rnd_counter(rc[g]),
            .rnd_lr1(lr1[g]),
            .busy(busy[g])
        );
    end

    // Datapath models: dut1 returns lr0 ^ round index, others loop back.
    logic [7:0] pipe [ND][8];
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            pipe[d][0] <= (d == 1) ? (lr0[d] ^ {3'b000, rc[d]}) : lr0[d];
            for (int i = 1; i < 8; i++) pipe[d][i] <= pipe[d][i-1];
        end
    end
    always_comb begin
        lr1 = '0;
        for (int d = 0; d < ND; d++) lr1[d] = pipe[d][LATS[d]-1];
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_cnt, act, exp);
        end
    endtask

    typedef struct {
        int           dut;
        logic [127:0] data;
        int           due;
    } exp_t;
    exp_t sb[$];

    // Monitor: pops on each out_valid rise, checks hold stability and invariants.
    logic [ND-1:0]        ov_prev = '0;
    logic [ND-1:0][127:0] held = '0;
    always @(negedge clk) begin
        if (cyc_cnt > 0) begin
            for (int d = 0; d < ND; d++) begin
                if (out_valid[d] && !ov_prev[d]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", {96'd0, 32'(d)}, 128'hFFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_dut", 128'(d), 128'(e.dut));
                        chk("out_data", out_data[d], e.data);
                        chk("out_latency", 128'(cyc_cnt), 128'(e.due));
                    end
                end else if (out_valid[d] && ov_prev[d]) begin
                    chk("out_hold", out_data[d], held[d]);
                end
                held[d] <= out_data[d];
            end
            chk("valid_ready_excl", 128'(out_valid & in_ready), 128'd0);
            chk("sk_eq_valid", 128'(sk), 128'(rv));
            ov_prev <= out_valid;
        end
    end

    // Present a block at a negedge; accept happens on the following posedge.
    // Returns at the negedge of the first issue cycle.
    task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp, input bit push);
        @(negedge clk);
        chk("send_in_ready", 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        if (push) sb.push_back('{d, exp, cyc_cnt + RND[d] * (LATS[d] + 16) + 1});
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!in_ready[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 128'(in_ready[d]), 128'd1);
    endtask

    task automatic chk_rst(input int d);
        chk("rst_in_ready", 128'(in_ready[d]), 128'd1);
        chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
        chk("rst_out_data", out_data[d], 128'd0);
        chk("rst_lr0", 128'(lr0[d]), 128'd0);
        chk("rst_rnd_valid", 128'(rv[d]), 128'd0);
        chk("rst_sk_req", 128'(sk[d]), 128'd0);
        chk("rst_counter", 128'(rc[d]), 128'd0);
        chk("rst_busy", 128'(busy[d]), 128'd0);
    endtask

    localparam logic [127:0] D0  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D2  = 128'hDEADBEEF0123456789ABCDEFF0E1D2C3;
    localparam logic [127:0] DBP = 128'hA55A3CC30F1E2D3C4B5A69788796A5B4;

    initial begin
        logic [ND-1:0] seen_rv;
        logic [ND-1:0] lost_rdy;
        int n;

        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk_rst(d);
        reset_n = 1'b1;

        // Idle for 100 cycles: nothing issued, always ready.
        seen_rv = '0;
        lost_rdy = '0;
        repeat (100) begin
            @(negedge clk);
            seen_rv  = seen_rv | rv;
            lost_rdy = lost_rdy | ~in_ready;
        end
        chk("idle_rnd_valid", 128'(seen_rv), 128'd0);
        chk("idle_in_ready", 128'(lost_rdy), 128'd0);

        // Loopback, defaults: result equals input, counter steps every 24 cycles.
        send(0, D0, D0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk("rc_round_start", 128'(rc[0]), 128'(k));
            chk("rv_round_start", 128'(rv[0]), 128'd1);
            chk("lr0_round_start", 128'(lr0[0]), 128'h00);
            @(negedge clk);
            chk("lr0_second_byte", 128'(lr0[0]), 128'h11);
            repeat (22) @(negedge clk);
            chk("rc_round_end", 128'(rc[0]), 128'(k));
            chk("rv_round_end", 128'(rv[0]), 128'd0);
            chk("lr0_round_end", 128'(lr0[0]), 128'd0);
            @(negedge clk);
        end
        wait_idle(0);

        // XOR-with-round datapath, ROUNDS=2.
        send(1, 128'd0, {16{8'h01}}, 1'b1);
        wait_idle(1);
        send(1, {16{8'hFF}}, {16{8'hFE}}, 1'b1);
        wait_idle(1);

        // Overlapping issue/capture windows: LAT=1, ROUNDS=3.
        send(2, D2, D2, 1'b1);
        wait_idle(2);

        // Back-pressure on result; in_valid pulses while DONE must be ignored.
        out_ready[0] = 1'b0;
        send(0, DBP, DBP, 1'b1);
        n = 0;
        while (!out_valid[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_valid", 128'(out_valid[0]), 128'd1);
        for (int i = 0; i < 50; i++) begin
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_out_data", out_data[0], DBP);
            in_valid[0] = (i % 7 == 3);
            in_data[0]  = {4{$urandom}};
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 128'(in_ready[0]), 128'd1);
        chk("bp_release_valid", 128'(out_valid[0]), 128'd0);
        repeat (20) @(negedge clk);

        // Kill a block at cyc=10 of round 5; no result may follow.
        send(0, D0, D0, 1'b0);
        repeat (5 * 24 + 10) @(negedge clk);
        chk("kill_point_round", 128'(rc[0]), 128'd5);
        chk("kill_point_busy", 128'(busy[0]), 128'd1);
`ifdef SEED_CTRL_ABORT_EN
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
`else
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif
        chk_rst(0);
        repeat (450) @(negedge clk);
        chk("kill_no_output", 128'(out_valid[0]), 128'd0);

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
